// File: rtl/seg7_capture.sv
// Readback decoder for a multiplexed active-low 7-segment bus.
// Recovers the per-position hex value plus blank and error status.
module seg7_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clear_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    update,
    output logic [2:0]              update_idx,
    output logic                    pat_err,
    output logic                    sel_err
);

    localparam int unsigned SW = NUM_DIGITS + 7;
    localparam int unsigned CW = 8;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HELD = 1'b1
    } state_e;

    logic [SW-1:0]           meta_q, s_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    update_q, update_d;
    logic [2:0]              idx_q, idx_d;
    logic                    pat_err_q, pat_err_d;
    logic                    sel_err_q, sel_err_d;

    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic                    s_change;
    logic [3:0]              n_low;
    logic [2:0]              low_idx;
    logic [4:0]              dec;

    // Inverse of the hex encoder: {hit, value}
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        an_s      = s_q[SW-1:7];
        seg_s     = s_q[6:0];
        s_change  = (meta_q != s_q);
        dec       = decode(seg_s);
        n_low     = 4'd0;
        low_idx   = 3'd0;
        cnt_d     = cnt_q;
        state_d   = state_q;
        digits_d  = digits_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        update_d  = 1'b0;
        idx_d     = idx_q;
        pat_err_d = pat_err_q & ~clear_err;
        sel_err_d = sel_err_q & ~clear_err;

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (!an_s[i]) begin
                n_low   = n_low + 4'd1;
                low_idx = 3'(i);
            end
        end

        // meta_q is the value s_q takes on this edge, so this compares new s against previous s
        if (s_change) begin
            cnt_d = '0;
        end else if (cnt_q < CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (state_q == ST_WAIT && cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_d = s_change ? ST_WAIT : ST_HELD;
            if (n_low > 4'd1) begin
                sel_err_d = 1'b1;
            end else if (n_low == 4'd1) begin
                update_d = 1'b1;
                idx_d    = low_idx;
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (!an_s[i]) begin
                        if (dec[4]) begin
                            digits_d[4*i +: 4] = dec[3:0];
                            valid_d[i]         = 1'b1;
                            blank_d[i]         = 1'b0;
                        end else if (seg_s == 7'b1111111) begin
                            valid_d[i] = 1'b0;
                            blank_d[i] = 1'b1;
                        end else begin
                            pat_err_d  = 1'b1;
                            valid_d[i] = 1'b0;
                            blank_d[i] = 1'b0;
                        end
                    end
                end
            end
        end else if (state_q == ST_HELD && s_change) begin
            state_d = ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q    <= '1;
            s_q       <= '1;
            cnt_q     <= '0;
            state_q   <= ST_WAIT;
            digits_q  <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            update_q  <= 1'b0;
            idx_q     <= 3'd0;
            pat_err_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            meta_q    <= {an_n, seg_n};
            s_q       <= meta_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            update_q  <= update_d;
            idx_q     <= idx_d;
            pat_err_q <= pat_err_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign digit_blank = blank_q;
    assign update      = update_q;
    assign update_idx  = idx_q;
    assign pat_err     = pat_err_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_capture;

    localparam int unsigned ND = 4;

    logic          clk;
    logic          reset_n;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;
    logic          clear_err;
    logic [4*ND-1:0] digits;
    logic [ND-1:0] digit_valid;
    logic [ND-1:0] digit_blank;
    logic          update;
    logic [2:0]    update_idx;
    logic          pat_err;
    logic          sel_err;

    int vectors = 0;
    int errors  = 0;
    int upd_cnt = 0;
    logic [2:0] last_idx = 3'd0;

    seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clear_err   (clear_err),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .update      (update),
        .update_idx  (update_idx),
        .pat_err     (pat_err),
        .sel_err     (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (update === 1'b1) begin
                upd_cnt++;
                last_idx = update_idx;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        an_n      = 4'b1111;
        seg_n     = 7'b1111111;
        clear_err = 1'b0;
        tick(3);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_update", 32'(update), 32'h0);
        reset_n = 1'b1;

        // Idle bus
        upd_cnt = 0;
        tick(50);
        chk("idle_upd_cnt", 32'(upd_cnt), 32'd0);
        chk("idle_digits", 32'(digits), 32'h0);
        chk("idle_valid", 32'(digit_valid), 32'h0);
        chk("idle_blank", 32'(digit_blank), 32'h0);
        chk("idle_errs", 32'({pat_err, sel_err}), 32'h0);

        // Single digit 2 on position 0, latency check
        upd_cnt = 0;
        an_n  = 4'b1110;
        seg_n = 7'b0100100;
        tick(5);
        chk("lat_no_upd_k4", 32'(upd_cnt), 32'd0);
        tick(1);
        chk("lat_upd_k5", 32'(update), 32'h1);
        chk("lat_idx", 32'(update_idx), 32'd0);
        chk("lat_digits", 32'(digits), 32'h0002);
        chk("lat_valid", 32'(digit_valid), 32'b0001);
        tick(1);
        chk("lat_upd_drop", 32'(update), 32'h0);
        tick(3);
        chk("lat_one_pulse", 32'(upd_cnt), 32'd1);

        // Scan: 3, A, blank, F
        upd_cnt = 0;
        an_n = 4'b1110; seg_n = 7'b0110000; tick(8);
        an_n = 4'b1101; seg_n = 7'b0001000; tick(8);
        an_n = 4'b1011; seg_n = 7'b1111111; tick(8);
        an_n = 4'b0111; seg_n = 7'b0001110; tick(8);
        chk("scan_upd_cnt", 32'(upd_cnt), 32'd4);
        chk("scan_last_idx", 32'(last_idx), 32'd3);
        chk("scan_digits", 32'(digits), 32'hF0A3);
        chk("scan_valid", 32'(digit_valid), 32'b1011);
        chk("scan_blank", 32'(digit_blank), 32'b0100);

        // Two anodes low
        upd_cnt = 0;
        an_n = 4'b1100; seg_n = 7'b0100100; tick(8);
        chk("sel_upd_cnt", 32'(upd_cnt), 32'd0);
        chk("sel_err_set", 32'(sel_err), 32'h1);
        chk("sel_digits", 32'(digits), 32'hF0A3);
        clear_err = 1'b1; tick(1); clear_err = 1'b0;
        tick(1);
        chk("sel_err_clr", 32'(sel_err), 32'h0);

        // Pattern outside the table on position 1
        upd_cnt = 0;
        an_n = 4'b1101; seg_n = 7'b1010101; tick(8);
        chk("pat_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("pat_idx", 32'(last_idx), 32'd1);
        chk("pat_err_set", 32'(pat_err), 32'h1);
        chk("pat_valid", 32'(digit_valid), 32'b1001);
        chk("pat_digits", 32'(digits), 32'hF0A3);
        chk("pat_blank", 32'(digit_blank), 32'b0100);

        // Glitch: 3-cycle hold must not capture
        upd_cnt = 0;
        an_n = 4'b1110; seg_n = 7'b0011001; tick(3);
        an_n = 4'b1111; seg_n = 7'b1111111; tick(10);
        chk("glitch_upd_cnt", 32'(upd_cnt), 32'd0);
        chk("glitch_digits", 32'(digits), 32'hF0A3);

        // Exactly STABLE_CYCLES hold captures
        upd_cnt = 0;
        an_n = 4'b1101; seg_n = 7'b1000000; tick(4);
        an_n = 4'b1111; seg_n = 7'b1111111; tick(10);
        chk("minhold_upd_cnt", 32'(upd_cnt), 32'd1);
        chk("minhold_digits", 32'(digits), 32'hF003);
        chk("minhold_valid", 32'(digit_valid), 32'b1011);

        // Reset mid-hold, then fresh full hold
        upd_cnt = 0;
        an_n = 4'b1110; seg_n = 7'b0011001; tick(3);
        reset_n = 1'b0;
        #1;
        chk("mrst_digits", 32'(digits), 32'h0);
        chk("mrst_flags", 32'({digit_valid, digit_blank, pat_err, sel_err, update}), 32'h0);
        tick(1);
        reset_n = 1'b1;
        upd_cnt = 0;
        tick(5);
        chk("mrst_no_early", 32'(upd_cnt), 32'd0);
        tick(1);
        chk("mrst_upd", 32'(update), 32'h1);
        chk("mrst_digits2", 32'(digits), 32'h0004);
        chk("mrst_valid", 32'(digit_valid), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects).
- Recovers the hex digit shown on each position, plus blank and error status.
- Used as the loopback and readback end of the display path: self-test of the display driver and bench checking of board outputs.
- Inverse of the hex-to-segment encoder; all inputs are treated as asynchronous pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (2..255)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
seg_n  input  7  segment lines, active-low; bit0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6=g
an_n  input  NUM_DIGITS  digit selects, active-low; bit i selects position i
clear_err  input  1  synchronous clear of sticky error flags
digits  output  4*NUM_DIGITS  last decoded value per position; position i occupies bits [4i+3:4i]
digit_valid  output  NUM_DIGITS  position holds a decoded hex value
digit_blank  output  NUM_DIGITS  position last captured as all-segments-off
update  output  1  one-cycle pulse on any capture
update_idx  output  3  position index of the capture; valid only while update=1
pat_err  output  1  sticky flag: a captured pattern is not in the decode table
sel_err  output  1  sticky flag: more than one anode was stably active

Behaviour:
- Reset (async assert, sync release): all outputs 0, sync flops 1 (idle bus), counter 0, state WAIT.
- Input sync: two-flop synchronizer on {an_n, seg_n}. Call its output s.
- Stability counter cnt:
  - If s equals the previous s, cnt increments, saturating at STABLE_CYCLES.
  - Otherwise cnt clears to 0.
- State machine:
  - WAIT -> capture and go to HELD on the edge where cnt reaches STABLE_CYCLES-1, i.e. s has been identical for STABLE_CYCLES edges.
  - HELD -> WAIT on any change of s. No recapture while in HELD.
  - Latency: new pin value first sampled at edge k; capture registers and update change at edge k+STABLE_CYCLES+1.
- Capture action by anode state:
  - an_n all 1: no capture, no update.
  - More than one anode low: sel_err<=1, no update, digit registers unchanged.
  - Exactly one low (position i): update<=1 and update_idx<=i, then decode seg_n as below.
- Decode table (seg_n -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B
  - 1000110->C, 0100001->D, 0000110->E, 0001110->F
- Decode outcome for position i:
  - Table match: digits[i]<=value, valid[i]<=1, blank[i]<=0.
  - seg_n=1111111: blank[i]<=1, valid[i]<=0, digits[i] unchanged.
  - Anything else: pat_err<=1, valid[i]<=0, blank[i]<=0, digits[i] unchanged.
- Ambiguous all-on pattern: 0000000 (lamp test) decodes as 8. It is not distinguishable from a lamp test and is not flagged.
- update deasserts on the next edge. Back-to-back captures are impossible because STABLE_CYCLES>=2.
- clear_err: clears both sticky error flags on the next edge. If a new error is detected on the same edge, set wins.
- Reset mid-capture: counter and state return to WAIT; the pattern must be re-held STABLE_CYCLES after release to capture.
- Glitch rejection: any s change shorter than STABLE_CYCLES edges produces no capture.

Test Plan:
- Reset, idle bus (all 1s) for 50 cycles -> no update; all outputs 0.
- an_n=1110, seg_n=0100100 held 10 cycles -> exactly one update pulse at edge k+5, update_idx=0, digits[3:0]=2, digit_valid=0001.
- Scan positions 0..3 with 3, A, 1111111, F, each held 8 cycles -> digits=F?A3 with position 2 unchanged, valid=1011, blank=0100, four update pulses.
- an_n=1100, any seg held 8 cycles -> sel_err=1, no update; then clear_err pulse -> sel_err=0.
- an_n=1101, seg_n=1010101 held 8 cycles -> update with idx=1, pat_err=1, valid[1]=0, digits[7:4] unchanged.
- Glitches: valid pattern held 3 cycles (STABLE_CYCLES=4) -> no update. Separately, reset_n pulsed low mid-hold -> all outputs 0 and a capture occurs only after a fresh full hold.
